regfile_wb_ctrl: RTL and testbench
==================================

// Module: regfile_wb_ctrl
// PURPOSE
//  Write-side controller for the 32x32 register file. Arbitrates ALU and LSU results onto the single
//  register-file write port (RegWrite / Write_Reg_Num / WriteData), one write per cycle.
//  Keeps a per-register busy scoreboard, set at issue and cleared at writeback. Stalls issue on RAW/WAW hazards.
//  Sits between the execute/memory stages and the register file.
// PARAMETERS
//  XLEN      32  data width of result and write ports
//  NREG      32  number of architectural registers; x0 is hardwired zero
//  CNT_W     16  width of the retired-write counter
// PORTS
//  clk            in   1      rising-edge clock
//  reset          in   1      asynchronous, active-low
//  alu_valid      in   1      ALU result valid; held until alu_ready
//  alu_rd         in   5      ALU destination register
//  alu_data       in   XLEN   ALU result
//  alu_ready      out  1      ALU result accepted this cycle (combinational grant)
//  lsu_valid      in   1      load result valid; held until lsu_ready
//  lsu_rd         in   5      load destination register
//  lsu_data       in   XLEN   load data
//  lsu_ready      out  1      load result accepted this cycle (combinational grant)
//  issue_valid    in   1      decode presents an instruction
//  issue_rs1      in   5      source 1
//  issue_rs2      in   5      source 2
//  issue_rd       in   5      destination
//  issue_rd_we    in   1      instruction writes rd
//  issue_stall    out  1      hazard: hold decode this cycle
//  RegWrite       out  1      register-file write enable (registered)
//  Write_Reg_Num  out  5      register-file write address (registered)
//  WriteData      out  XLEN   register-file write data (registered)
//  wb_count       out  CNT_W  number of RegWrite pulses since reset; wraps at 2^CNT_W
// BEHAVIOUR
//  Reset:
//   - RegWrite=0, Write_Reg_Num=0, WriteData=0, wb_count=0.
//   - busy[31:0]=0; rr_last=ALU, so the LSU wins the first tie.
//   - A mid-operation reset drops all pending grants and the scoreboard.
//  Arbitration (per cycle):
//   - Only one valid source: it is granted.
//   - Both valid: round-robin. The source not granted last wins; rr_last updates on every grant.
//   - Grant drives the corresponding *_ready high in the same cycle.
//  Writeback:
//   - A grant at edge N produces RegWrite=1 for exactly cycle N+1, with Write_Reg_Num/WriteData latched.
//   - No grant -> RegWrite=0; address and data hold their previous values.
//   - Latency is 1 cycle. Throughput is 1 write/cycle with no bubbles when both sources stream.
//  x0:
//   - A result with rd=0 is accepted (ready=1) and consumed, but RegWrite stays 0 and wb_count does not increment.
//   - x0 is never marked busy.
//  Scoreboard:
//   - issue_fire = issue_valid & ~issue_stall & issue_rd_we & (issue_rd!=0) -> sets busy[issue_rd] at the next edge.
//   - busy[Write_Reg_Num] clears at the edge closing a cycle in which RegWrite=1.
//   - Set and clear of the same register on the same edge: set wins (newer producer outstanding).
//  Stall:
//   - issue_stall = issue_valid & (busy[rs1] | busy[rs2] | (issue_rd_we & busy[rd])), using registered busy only.
//   - No same-cycle bypass. A consumer of a register written in cycle N+1 unstalls in cycle N+2.
//  Counter: wb_count increments on every cycle with RegWrite=1 and wraps to 0 silently.
//  Protocol:
//   - A source must not change rd/data while valid & ~ready.
//   - Dropping valid without ready is illegal; the bench asserts against it.
// STRUCTURE
//  - Shared package rv_pkg: XLEN, NREG, REG_X0=5'd0, typedef reg_idx_t [4:0], typedef wb_src_e {WB_ALU, WB_LSU}.
//  - One sub-module: wb_rr_arbiter (2-requester round-robin, grant + rr_last flop).
//  - Scoreboard, write register and counter stay inline.
// TESTING
//  1 Reset: hold reset=0 with both sources valid -> RegWrite=0, ready=0, busy=0, wb_count=0;
//    release -> first grant goes to the LSU.
//  2 Single write: alu_valid, rd=5, data=32'hDEADBEEF at edge N -> alu_ready=1 in cycle N;
//    cycle N+1 has RegWrite=1, Write_Reg_Num=5, WriteData=DEADBEEF; wb_count=1.
//  3 Contention: both valid for 4 cycles (ALU rd=1..4, LSU rd=9..12) -> grants alternate LSU,ALU,LSU,ALU;
//    8 writes in 8 consecutive cycles.
//  4 RAW hazard: issue rd=7, then issue rs1=7 -> issue_stall=1 until 1 cycle after the RegWrite to x7, then 0.
//  5 x0 and same-edge set/clear: result to rd=0 -> ready=1, RegWrite stays 0;
//    issue rd=3 on the same edge as the writeback of x3 -> busy[3] remains 1.
//  6 Mid-operation reset with busy=0x0000_00F0 and a grant pending -> all outputs and busy return to reset values;
//    no RegWrite pulse follows.

Source files
------------

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv_pkg
//  Purpose  : Shared types and sizing constants for the register-file
//             write-side slice (data width, register count, source encoding).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package rv_pkg;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int CNT_W = 16;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_X0 = 5'd0;

    // Identifies which execution unit owns a writeback slot.
    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

endpackage : rv_pkg
`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_rr_arbiter
//  Purpose  : Two-requester round-robin arbiter for the single register-file
//             write port. The requester that did not win last time wins a tie.
//  Ports    : clk        rising-edge clock
//             reset      asynchronous, active-low
//             req_alu_i  ALU result pending
//             req_lsu_i  LSU result pending
//             gnt_alu_o  ALU granted this cycle (combinational)
//             gnt_lsu_o  LSU granted this cycle (combinational)
//  Revision : 1.0  initial release
// ============================================================================
module wb_rr_arbiter
    import rv_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_alu_i,
    input  logic req_lsu_i,
    output logic gnt_alu_o,
    output logic gnt_lsu_o
);

    wb_src_e rr_last_q;

    // Grants are masked while reset is asserted so an in-flight result is
    // not consumed by a cycle that the write register will discard.
    always_comb begin
        gnt_lsu_o = reset & req_lsu_i & (~req_alu_i | (rr_last_q == WB_ALU));
        gnt_alu_o = reset & req_alu_i & ~gnt_lsu_o;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_last_q <= WB_ALU;   // LSU wins the first tie after reset
        end else if (gnt_lsu_o) begin
            rr_last_q <= WB_LSU;
        end else if (gnt_alu_o) begin
            rr_last_q <= WB_ALU;
        end
    end

endmodule : wb_rr_arbiter
`default_nettype wire

// File: rtl/regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_ctrl
//  Purpose  : Write-side controller for the 32x32 register file. Arbitrates
//             ALU and LSU results onto one registered write port, keeps a
//             per-register busy scoreboard and stalls issue on RAW/WAW hazards.
//  Ports    : clk, reset (async, active-low)
//             alu_valid/alu_rd/alu_data -> alu_ready   ALU result handshake
//             lsu_valid/lsu_rd/lsu_data -> lsu_ready   load result handshake
//             issue_valid/rs1/rs2/rd/rd_we -> issue_stall  decode hazard check
//             RegWrite/Write_Reg_Num/WriteData          registered write port
//             wb_count                                  retired-write counter
//  Revision : 1.0  initial release
// ============================================================================
module regfile_wb_ctrl
    import rv_pkg::*;
#(
    parameter int XLEN  = rv_pkg::XLEN,
    parameter int NREG  = rv_pkg::NREG,
    parameter int CNT_W = rv_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid,
    input  logic [4:0]       alu_rd,
    input  logic [XLEN-1:0]  alu_data,
    output logic             alu_ready,
    input  logic             lsu_valid,
    input  logic [4:0]       lsu_rd,
    input  logic [XLEN-1:0]  lsu_data,
    output logic             lsu_ready,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rs1,
    input  logic [4:0]       issue_rs2,
    input  logic [4:0]       issue_rd,
    input  logic             issue_rd_we,
    output logic             issue_stall,
    output logic             RegWrite,
    output logic [4:0]       Write_Reg_Num,
    output logic [XLEN-1:0]  WriteData,
    output logic [CNT_W-1:0] wb_count
);

    logic             gnt_alu;
    logic             gnt_lsu;
    logic             wr_en_d;
    reg_idx_t         wr_rd_d;
    logic [XLEN-1:0]  wr_data_d;
    logic             issue_fire;
    logic [NREG-1:0]  busy_d;
    logic [NREG-1:0]  busy_q;

    logic             regwrite_q;
    reg_idx_t         wr_rd_q;
    logic [XLEN-1:0]  wr_data_q;
    logic [CNT_W-1:0] wb_count_q;

    wb_rr_arbiter u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_alu_i (alu_valid),
        .req_lsu_i (lsu_valid),
        .gnt_alu_o (gnt_alu),
        .gnt_lsu_o (gnt_lsu)
    );

    assign alu_ready = gnt_alu;
    assign lsu_ready = gnt_lsu;

    // Results to x0 are consumed but never reach the write port.
    always_comb begin
        wr_rd_d   = gnt_lsu ? lsu_rd   : alu_rd;
        wr_data_d = gnt_lsu ? lsu_data : alu_data;
        wr_en_d   = (gnt_alu | gnt_lsu) & (wr_rd_d != REG_X0);
    end

    // Stall looks only at registered busy bits: a result being written this
    // cycle still blocks its consumers until the following cycle.
    always_comb begin
        issue_stall = issue_valid & (busy_q[issue_rs1] | busy_q[issue_rs2] |
                                     (issue_rd_we & busy_q[issue_rd]));
        issue_fire  = issue_valid & ~issue_stall & issue_rd_we & (issue_rd != REG_X0);
    end

    // Set is applied after clear so a new producer issued on the writeback
    // edge of the old one keeps the register marked outstanding.
    always_comb begin
        busy_d = busy_q;
        if (regwrite_q) begin
            busy_d[wr_rd_q] = 1'b0;
        end
        if (issue_fire) begin
            busy_d[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regwrite_q <= 1'b0;
            wr_rd_q    <= REG_X0;
            wr_data_q  <= '0;
            wb_count_q <= '0;
            busy_q     <= '0;
        end else begin
            regwrite_q <= wr_en_d;
            busy_q     <= busy_d;
            if (wr_en_d) begin
                wr_rd_q    <= wr_rd_d;
                wr_data_q  <= wr_data_d;
                // Counted with the pulse so wb_count already includes it.
                wb_count_q <= wb_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign RegWrite      = regwrite_q;
    assign Write_Reg_Num = wr_rd_q;
    assign WriteData     = wr_data_q;
    assign wb_count      = wb_count_q;

endmodule : regfile_wb_ctrl
`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_ctrl
//  Purpose  : Directed self-checking bench for regfile_wb_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wb_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [4:0]  issue_rd;
    logic        issue_rd_we;
    logic        issue_stall;
    logic        RegWrite;
    logic [4:0]  Write_Reg_Num;
    logic [31:0] WriteData;
    logic [15:0] wb_count;

    int checks = 0;
    int passes = 0;

    regfile_wb_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .alu_ready     (alu_ready),
        .lsu_valid     (lsu_valid),
        .lsu_rd        (lsu_rd),
        .lsu_data      (lsu_data),
        .lsu_ready     (lsu_ready),
        .issue_valid   (issue_valid),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_rd      (issue_rd),
        .issue_rd_we   (issue_rd_we),
        .issue_stall   (issue_stall),
        .RegWrite      (RegWrite),
        .Write_Reg_Num (Write_Reg_Num),
        .WriteData     (WriteData),
        .wb_count      (wb_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake rule: a pending (valid & ~ready) source must keep valid up.
    logic alu_pend = 1'b0;
    logic lsu_pend = 1'b0;
    always @(negedge clk) begin
        if (reset === 1'b1 && alu_pend && !alu_valid) begin
            checks++;
            $error("FAIL proto_alu_drop observed=0 expected=1");
        end
        if (reset === 1'b1 && lsu_pend && !lsu_valid) begin
            checks++;
            $error("FAIL proto_lsu_drop observed=0 expected=1");
        end
        alu_pend = (reset === 1'b1) && alu_valid && !alu_ready;
        lsu_pend = (reset === 1'b1) && lsu_valid && !lsu_ready;
    end

    initial begin
        int ai;
        int li;
        reset       = 1'b0;
        alu_valid   = 1'b1; alu_rd = 5'd1; alu_data = 32'h1111_0001;
        lsu_valid   = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h2222_0002;
        issue_valid = 1'b0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
        issue_rd    = 5'd0; issue_rd_we = 1'b0;

        // ---- 1: reset with both sources valid ----
        tick(); tick();
        chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        chk("rst_busy", dut.busy_q, 32'd0);
        chk("rst_count", {16'd0, wb_count}, 32'd0);
        chk("rst_num", {27'd0, Write_Reg_Num}, 32'd0);
        chk("rst_data", WriteData, 32'd0);
        reset = 1'b1;
        #1;
        chk("first_gnt_lsu", {31'd0, lsu_ready}, 32'd1);
        chk("first_gnt_alu", {31'd0, alu_ready}, 32'd0);
        tick();
        chk("first_wr", {31'd0, RegWrite}, 32'd1);
        chk("first_num", {27'd0, Write_Reg_Num}, 32'd2);
        chk("first_data", WriteData, 32'h2222_0002);
        lsu_valid = 1'b0;
        #1;
        chk("pend_alu_gnt", {31'd0, alu_ready}, 32'd1);
        tick();
        chk("pend_alu_num", {27'd0, Write_Reg_Num}, 32'd1);
        chk("cnt_after_two", {16'd0, wb_count}, 32'd2);

        // ---- 2: single ALU write ----
        alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        chk("single_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        chk("single_wr", {31'd0, RegWrite}, 32'd1);
        chk("single_num", {27'd0, Write_Reg_Num}, 32'd5);
        chk("single_data", WriteData, 32'hDEADBEEF);
        chk("single_cnt", {16'd0, wb_count}, 32'd3);
        alu_valid = 1'b0;
        tick();
        chk("idle_wr", {31'd0, RegWrite}, 32'd0);
        chk("idle_num_hold", {27'd0, Write_Reg_Num}, 32'd5);
        chk("idle_data_hold", WriteData, 32'hDEADBEEF);
        chk("idle_cnt", {16'd0, wb_count}, 32'd3);

        // ---- 3: contention, ALU rd 1..4 vs LSU rd 9..12 ----
        ai = 0; li = 0;
        alu_valid = 1'b1; alu_rd = 5'd1;  alu_data = 32'hA000_0001;
        lsu_valid = 1'b1; lsu_rd = 5'd9;  lsu_data = 32'hB000_0009;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("rr_lsu_ready", {31'd0, lsu_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_alu_ready", {31'd0, alu_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            chk("rr_wr", {31'd0, RegWrite}, 32'd1);
            if (i % 2 == 0) begin
                chk("rr_num", {27'd0, Write_Reg_Num}, 32'd9 + li);
                chk("rr_data", WriteData, 32'hB000_0009 + li);
                li++;
                lsu_rd = 5'(9 + li); lsu_data = 32'hB000_0009 + li;
                if (li == 4) lsu_valid = 1'b0;
            end else begin
                chk("rr_num", {27'd0, Write_Reg_Num}, 32'd1 + ai);
                chk("rr_data", WriteData, 32'hA000_0001 + ai);
                ai++;
                alu_rd = 5'(1 + ai); alu_data = 32'hA000_0001 + ai;
                if (ai == 4) alu_valid = 1'b0;
            end
        end
        chk("rr_cnt", {16'd0, wb_count}, 32'd11);

        // ---- 4: RAW hazard on x7 ----
        issue_valid = 1'b1; issue_rd = 5'd7; issue_rd_we = 1'b1;
        #1;
        chk("raw_prod_nostall", {31'd0, issue_stall}, 32'd0);
        tick();
        issue_rs1 = 5'd7; issue_rd = 5'd8;
        #1;
        chk("raw_stall0", {31'd0, issue_stall}, 32'd1);
        tick();
        chk("raw_stall1", {31'd0, issue_stall}, 32'd1);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_0077;
        #1;
        chk("raw_alu_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        alu_valid = 1'b0;
        chk("raw_wb_num", {27'd0, Write_Reg_Num}, 32'd7);
        #1;
        chk("raw_stall_wbcycle", {31'd0, issue_stall}, 32'd1);
        tick();
        chk("raw_unstall", {31'd0, issue_stall}, 32'd0);
        issue_valid = 1'b0; issue_rs1 = 5'd0;
        chk("raw_cnt", {16'd0, wb_count}, 32'd12);

        // ---- 5: x0 result and same-edge set/clear on x3 ----
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_1234;
        #1;
        chk("x0_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        alu_valid = 1'b0;
        chk("x0_no_wr", {31'd0, RegWrite}, 32'd0);
        chk("x0_cnt", {16'd0, wb_count}, 32'd12);
        chk("x0_num_hold", {27'd0, Write_Reg_Num}, 32'd7);
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h0000_0033;
        tick();
        lsu_valid = 1'b0;
        chk("x3_wr", {31'd0, RegWrite}, 32'd1);
        issue_valid = 1'b1; issue_rd = 5'd3; issue_rd_we = 1'b1;
        #1;
        chk("x3_issue_nostall", {31'd0, issue_stall}, 32'd0);
        tick();
        issue_rd_we = 1'b0; issue_rd = 5'd0; issue_rs1 = 5'd3;
        #1;
        chk("x3_busy_kept", dut.busy_q, 32'h0000_0008);
        chk("x3_consumer_stall", {31'd0, issue_stall}, 32'd1);
        issue_valid = 1'b0; issue_rs1 = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0303;
        tick();
        alu_valid = 1'b0;
        tick();
        chk("x3_cleared", dut.busy_q, 32'd0);
        chk("x3_cnt", {16'd0, wb_count}, 32'd14);

        // ---- 6: mid-operation reset ----
        issue_valid = 1'b1; issue_rd_we = 1'b1;
        for (int r = 4; r < 8; r++) begin
            issue_rd = 5'(r);
            tick();
        end
        issue_valid = 1'b0; issue_rd_we = 1'b0; issue_rd = 5'd0;
        chk("pre_rst_busy", dut.busy_q, 32'h0000_00F0);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0999;
        #1;
        chk("pre_rst_gnt", {31'd0, alu_ready}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, alu_ready}, 32'd0);
        chk("mid_rst_busy", dut.busy_q, 32'd0);
        chk("mid_rst_cnt", {16'd0, wb_count}, 32'd0);
        chk("mid_rst_num", {27'd0, Write_Reg_Num}, 32'd0);
        chk("mid_rst_data", WriteData, 32'd0);
        tick();
        chk("mid_rst_no_wr", {31'd0, RegWrite}, 32'd0);
        alu_valid = 1'b0;
        reset = 1'b1;
        issue_valid = 1'b1; issue_rs1 = 5'd4;
        #1;
        chk("post_rst_nostall", {31'd0, issue_stall}, 32'd0);
        issue_valid = 1'b0; issue_rs1 = 5'd0;
        tick();
        chk("post_rst_no_wr", {31'd0, RegWrite}, 32'd0);
        chk("post_rst_cnt", {16'd0, wb_count}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_regfile_wb_ctrl
`default_nettype wire
